vga_text_engine: RTL and testbench

//  Parametrised text-mode VGA engine, successor of the fixed 20MHz character display.

---
 rtl/vga_text_engine_if.sv | 22 ++
 rtl/vga_text_engine.sv | 185 ++++++++++++++++++
 tb/tb_vga_text_engine.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vga_text_engine_if.sv
// ============================================================================
// Module      : vga_text_engine_if
// Description : Fetch bus between the text engine and its char/attr RAM and
//               glyph ROM (both synchronous, data one clock after address).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_text_engine_if #(
    parameter int ROW_BITS = 6,
    parameter int COL_BITS = 6
);
    logic [ROW_BITS+COL_BITS:0] cram_addr;
    logic [7:0]                 cram_q;
    logic [10:0]                crom_addr;
    logic [7:0]                 crom_q;

    modport master (output cram_addr, output crom_addr, input cram_q, input crom_q);
    modport slave  (input cram_addr, input crom_addr, output cram_q, output crom_q);
endinterface

`default_nettype wire

// File: rtl/vga_text_engine.sv
// ============================================================================
// Module      : vga_text_engine
// Description : Text-mode VGA engine with programmable timing, attributes,
//               blinking cursor, frame-synchronous scroll and vblank status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_text_engine #(
    parameter int H_VIS        = 400,
    parameter int H_FP         = 20,
    parameter int H_SYNC       = 64,
    parameter int H_BP         = 44,
    parameter int V_VIS        = 600,
    parameter int V_FP         = 1,
    parameter int V_SYNC       = 4,
    parameter int V_BP         = 23,
    parameter bit HS_POL       = 1'b1,
    parameter bit VS_POL       = 1'b1,
    parameter int V_SHIFT      = 1,
    parameter int COL_BITS     = 6,
    parameter int ROW_BITS     = 6,
    parameter int BLINK_BITS   = 4,
    parameter int CURSOR_START = 6
) (
    input  wire logic                clk_20MHz,
    input  wire logic                reset,
    vga_text_engine_if.master        mem,
    input  wire logic                cursor_en,
    input  wire logic [COL_BITS-1:0] cursor_col,
    input  wire logic [ROW_BITS-1:0] cursor_row,
    input  wire logic [ROW_BITS-1:0] scroll_row,
    output logic                     h_sync,
    output logic                     v_sync,
    output logic [3:0]               R,
    output logic [3:0]               G,
    output logic [3:0]               B,
    output logic                     vblank,
    output logic                     frame_pulse
);
    localparam int HT     = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_BITS = $clog2(HT);
    localparam int V_BITS = $clog2(VT);

    logic [H_BITS-1:0]     h;
    logic [V_BITS-1:0]     v;
    logic [BLINK_BITS-1:0] frame_cnt;

    logic [ROW_BITS-1:0] scroll_lat, cur_row_lat;
    logic [COL_BITS-1:0] cur_col_lat;
    logic                cur_en_lat;

    logic [7:0] char_r, attr_r, glyph_r;
    logic [7:0] disp_attr, disp_glyph;
    logic       disp_vis, disp_cur;
    logic [7:0] hs_d, vs_d, vb_d;
    logic       vs_act;

    logic                h_last, v_last, frame_start, vs_lead;
    logic                raw_hs, raw_vs, raw_vb, cell_vis, cell_cur;
    logic [2:0]          phase, gline;
    logic [V_BITS-1:0]   ty;
    logic [ROW_BITS-1:0] row_screen, row_text, scroll_use;
    logic [COL_BITS-1:0] col;

    always_comb begin
        h_last      = (h == H_BITS'(HT - 1));
        v_last      = (v == V_BITS'(VT - 1));
        frame_start = (h == '0) && (v == '0);
        vs_lead     = (h == '0) && (v == V_BITS'(V_VIS + V_FP));
        raw_hs      = (h >= H_BITS'(H_VIS + H_FP)) && (h < H_BITS'(H_VIS + H_FP + H_SYNC));
        raw_vs      = (v >= V_BITS'(V_VIS + V_FP)) && (v < V_BITS'(V_VIS + V_FP + V_SYNC));
        raw_vb      = (v >= V_BITS'(V_VIS));
        phase       = h[2:0];
        ty          = v >> V_SHIFT;
        gline       = ty[2:0];
        row_screen  = ROW_BITS'(ty >> 3);
        col         = COL_BITS'(h >> 3);
        // Bypass the latch on the very first cycle so the new frame's first fetch already sees it
        scroll_use  = frame_start ? scroll_row : scroll_lat;
        row_text    = row_screen + scroll_use;
        cell_vis    = (h < H_BITS'(H_VIS)) && (v < V_BITS'(V_VIS));
        cell_cur    = cur_en_lat && (col == cur_col_lat) && (row_screen == cur_row_lat)
                      && (gline >= 3'(CURSOR_START));
        mem.cram_addr = {phase != 3'd0, row_text, col};
        mem.crom_addr = {char_r, gline};
    end

    logic       pix_bit, cur_on, is_fg, hide, bright;
    logic [2:0] colr;

    always_comb begin
        pix_bit = disp_glyph[h[2:0]];
        cur_on  = disp_cur & frame_cnt[BLINK_BITS-2];
        is_fg   = pix_bit ^ cur_on;
        hide    = is_fg & ~disp_attr[7] & ~frame_cnt[BLINK_BITS-1] & ~cur_on;
        colr    = is_fg ? disp_attr[6:4] : disp_attr[2:0];
        bright  = disp_attr[3] | is_fg;
    end

    always_ff @(posedge clk_20MHz) begin
        if (reset) begin
            h           <= '0;
            v           <= '0;
            frame_cnt   <= '0;
            scroll_lat  <= '0;
            cur_en_lat  <= 1'b0;
            cur_col_lat <= '0;
            cur_row_lat <= '0;
        end else begin
            h <= h_last ? '0 : h + 1'b1;
            if (h_last) v <= v_last ? '0 : v + 1'b1;
            if (frame_start) begin
                scroll_lat  <= scroll_row;
                cur_en_lat  <= cursor_en;
                cur_col_lat <= cursor_col;
                cur_row_lat <= cursor_row;
            end
            if (vs_lead) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Cell fetch: char, attr, glyph captured in successive phases, handed over at phase 7
    always_ff @(posedge clk_20MHz) begin
        if (reset) begin
            char_r     <= '0;
            attr_r     <= '0;
            glyph_r    <= '0;
            disp_attr  <= '0;
            disp_glyph <= '0;
            disp_vis   <= 1'b0;
            disp_cur   <= 1'b0;
        end else begin
            case (phase)
                3'd1: char_r  <= mem.cram_q;
                3'd2: attr_r  <= mem.cram_q;
                3'd3: glyph_r <= mem.crom_q;
                3'd7: begin
                    disp_attr  <= attr_r;
                    disp_glyph <= glyph_r;
                    disp_vis   <= cell_vis;
                    disp_cur   <= cell_cur;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_20MHz) begin
        if (reset) begin
            hs_d        <= '0;
            vs_d        <= '0;
            vb_d        <= '0;
            vs_act      <= 1'b0;
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            vblank      <= 1'b0;
            frame_pulse <= 1'b0;
            R           <= '0;
            G           <= '0;
            B           <= '0;
        end else begin
            hs_d        <= {hs_d[6:0], raw_hs};
            vs_d        <= {vs_d[6:0], raw_vs};
            vb_d        <= {vb_d[6:0], raw_vb};
            vs_act      <= vs_d[7];
            h_sync      <= hs_d[7] ? HS_POL : ~HS_POL;
            v_sync      <= vs_d[7] ? VS_POL : ~VS_POL;
            vblank      <= vb_d[7];
            frame_pulse <= vs_d[7] & ~vs_act;
            if (!disp_vis || hide) begin
                R <= '0;
                G <= '0;
                B <= '0;
            end else begin
                R <= {bright & colr[2], {3{colr[2]}}};
                G <= {bright & colr[1], {3{colr[1]}}};
                B <= {bright & colr[0], {3{colr[0]}}};
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_vga_text_engine.sv
// ============================================================================
// Module      : tb_vga_text_engine
// Description : Randomized bench for vga_text_engine against a frame-level
//               reference model of timing, fetch addresses and pixel colour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_text_engine;
    localparam int  H_VIS = 32, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int  V_VIS = 48, V_FP = 1, V_SYNC = 2, V_BP = 3;
    localparam bit  HS_POL = 1'b1, VS_POL = 1'b0;
    localparam int  BLINK_BITS = 3;
    localparam int  HT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int  VT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int  FT = HT * VT;

    logic       clk_20MHz = 1'b0;
    logic       reset = 1'b1;
    logic       cursor_en = 1'b1;
    logic [5:0] cursor_col = 6'd2, cursor_row = 6'd0, scroll_row = 6'd0;
    logic       h_sync, v_sync, vblank, frame_pulse;
    logic [3:0] R, G, B;

    logic [7:0] cram [0:8191];
    logic [7:0] crom [0:2047];
    int         sc_hist [0:15];
    int         cen_hist[0:15];
    int         ccol_hist[0:15];
    int         crow_hist[0:15];
    int         checks = 0, errors = 0;

    vga_text_engine_if #(.ROW_BITS(6), .COL_BITS(6)) mem ();

    vga_text_engine #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .V_SHIFT(1), .COL_BITS(6), .ROW_BITS(6),
        .BLINK_BITS(BLINK_BITS), .CURSOR_START(6)
    ) dut (
        .clk_20MHz(clk_20MHz), .reset(reset), .mem(mem.master),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .scroll_row(scroll_row), .h_sync(h_sync), .v_sync(v_sync),
        .R(R), .G(G), .B(B), .vblank(vblank), .frame_pulse(frame_pulse)
    );

    always #5 clk_20MHz = ~clk_20MHz;

    always @(posedge clk_20MHz) begin
        mem.cram_q <= cram[mem.cram_addr];
        mem.crom_q <= crom[mem.crom_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Screen text row for a frame-relative position
    function automatic int text_row(int v, int f);
        return (((v >> 1) / 8) + sc_hist[f]) % 64;
    endfunction

    function automatic logic [3:0] exp_sync(int p);
        int f, w, v, h;
        logic hs, vs;
        if (p < 0) return {~HS_POL, ~VS_POL, 2'b00};
        f  = p / FT; w = p % FT; v = w / HT; h = w % HT;
        hs = (h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC);
        vs = (v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC);
        return {hs ? HS_POL : ~HS_POL, vs ? VS_POL : ~VS_POL,
                v >= V_VIS, (h == 0) && (v == V_VIS + V_FP)};
    endfunction

    function automatic logic [11:0] exp_rgb(int p);
        int f, w, v, h, rs, gl, col, rt, fc;
        logic [7:0] ch, at, g;
        logic cur, fg, br;
        logic [2:0] c;
        if (p < 0) return 12'h000;
        f = p / FT; w = p % FT; v = w / HT; h = w % HT;
        if (h >= H_VIS || v >= V_VIS) return 12'h000;
        rs  = (v >> 1) / 8;
        gl  = (v >> 1) % 8;
        col = h / 8;
        rt  = text_row(v, f);
        ch  = cram[rt * 64 + col];
        at  = cram[4096 + rt * 64 + col];
        g   = crom[ch * 8 + gl];
        fc  = f % (1 << BLINK_BITS);
        cur = (cen_hist[f] != 0) && (col == ccol_hist[f]) && (rs == crow_hist[f]) && (gl >= 6)
              && (((fc >> (BLINK_BITS - 2)) & 1) == 1);
        fg  = g[h % 8] ^ cur;
        if (fg && !cur && !at[7] && fc < (1 << (BLINK_BITS - 1))) return 12'h000;
        c   = fg ? at[6:4] : at[2:0];
        br  = at[3] | fg;
        return {br & c[2], {3{c[2]}}, br & c[1], {3{c[1]}}, br & c[0], {3{c[0]}}};
    endfunction

    // Releases reset, then runs n raw positions checking addresses and outputs
    task automatic run_segment(input int n);
        int f, w, v, h, rt;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_20MHz);
            if (k == 0) reset = 1'b0;
            else if ($urandom_range(0, 699) == 0) begin
                scroll_row = 6'($urandom_range(0, 63));
                cursor_en  = ($urandom_range(0, 3) != 0);
                cursor_col = 6'($urandom_range(0, 3));
                cursor_row = 6'($urandom_range(0, 2));
            end
            if (k % FT == 0) begin
                sc_hist[k / FT]   = int'(scroll_row);
                cen_hist[k / FT]  = int'(cursor_en);
                ccol_hist[k / FT] = int'(cursor_col);
                crow_hist[k / FT] = int'(cursor_row);
            end
            f = k / FT; w = k % FT; v = w / HT; h = w % HT;
            rt = text_row(v, f);
            if (h % 8 == 0) check_eq("cram_char", 32'(mem.cram_addr), 32'(rt * 64 + (h / 8) % 64));
            if (h % 8 == 1) check_eq("cram_attr", 32'(mem.cram_addr), 32'(4096 + rt * 64 + (h / 8) % 64));
            if (h % 8 == 2)
                check_eq("crom", 32'(mem.crom_addr),
                         32'(int'(cram[rt * 64 + (h / 8) % 64]) * 8 + (v >> 1) % 8));
            @(posedge clk_20MHz);
            #1;
            check_eq("sync", 32'({h_sync, v_sync, vblank, frame_pulse}), 32'(exp_sync(k - 8)));
            check_eq("rgb", 32'({R, G, B}), 32'(exp_rgb(k - 8)));
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) cram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) crom[i] = 8'($urandom);
        cram[0]        = 8'h41;
        cram[4096]     = 8'hF9;
        crom[8'h41 * 8] = 8'h81;
        repeat (3) @(posedge clk_20MHz);
        run_segment(12 * FT);

        @(negedge clk_20MHz);
        reset = 1'b1;
        @(posedge clk_20MHz);
        #1;
        check_eq("rst_sync", 32'({h_sync, v_sync, vblank, frame_pulse}), 32'({~HS_POL, ~VS_POL, 2'b00}));
        check_eq("rst_rgb", 32'({R, G, B}), 32'h0);
        repeat (2) @(posedge clk_20MHz);
        run_segment(3 * FT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
